// File: rtl/pipeline_step_ctrl.sv
// pipeline_step_ctrl
// Debug-path execution controller for the MIPS pipeline. Converts RUN, STEP
// and ABORT commands into the registered o_step enable for the PC and the
// pipeline registers, and drains in-flight instructions after a HALT fetch
// while holding the PC.
// Optional feature macro: PIPELINE_STEP_CTRL_TIMEOUT_EN (RUN-cycle watchdog).
// Without it, o_timeout is tied low and no watchdog logic is built.
module pipeline_step_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 4,
   parameter int unsigned SIZE_CNT     = 32,
   parameter int unsigned MAX_CYCLES   = 2**20
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_cmd_valid,
   input  logic [1:0]          i_cmd,
   output logic                o_cmd_ready,
   input  logic                i_halt_detected,
   output logic                o_step,
   output logic                o_pc_hold,
   output logic                o_done,
   output logic                o_timeout,
   output logic [2:0]          o_state,
   output logic [SIZE_CNT-1:0] o_cycle_count
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_STEP  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Drain down-counter is loaded with DRAIN_CYCLES-1 and exits at zero.
   localparam int unsigned   DW         = (DRAIN_CYCLES > 32'd1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0] DRAIN_LOAD = (DRAIN_CYCLES > 32'd0) ? DW'(DRAIN_CYCLES - 32'd1)
                                                                 : {DW{1'b0}};

   state_t                state_q, state_d;
   logic [DW-1:0]         drain_q, drain_d;
   logic [SIZE_CNT-1:0]   cnt_q, cnt_d;
   logic                  step_q, pc_hold_q, done_q, ready_q;
   logic                  cnt_clr_s;
   logic                  abort_s, run_cmd_s, step_cmd_s;
   logic                  wd_hit_s;

   // ABORT bypasses the ready handshake; RUN/STEP need o_cmd_ready (IDLE only).
   assign abort_s    = i_cmd_valid & (i_cmd == 2'b11);
   assign run_cmd_s  = i_cmd_valid & ready_q & (i_cmd == 2'b01);
   assign step_cmd_s = i_cmd_valid & ready_q & (i_cmd == 2'b10);

`ifdef PIPELINE_STEP_CTRL_TIMEOUT_EN
   localparam int unsigned   WW      = (MAX_CYCLES > 32'd1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [WW-1:0] WD_LAST = WW'(MAX_CYCLES - 32'd1);

   logic [WW-1:0] wd_q, wd_d;
   logic          timeout_q, timeout_d;

   // The watchdog fires on the MAX_CYCLES-th consecutive RUN cycle.
   assign wd_hit_s = (state_q == ST_RUN) && (wd_q == WD_LAST);

   // Watchdog and timeout-flag next state; HALT and ABORT take priority.
   always_comb begin
      wd_d      = {WW{1'b0}};
      timeout_d = timeout_q;
      if (abort_s) begin
         timeout_d = 1'b0;
      end else if (wd_hit_s && !i_halt_detected) begin
         timeout_d = 1'b1;
      end else begin
         timeout_d = timeout_q;
      end
      if (state_q == ST_RUN && state_d == ST_RUN) begin
         wd_d = wd_q + WW'(32'd1);
      end else begin
         wd_d = {WW{1'b0}};
      end
   end

   // Watchdog registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wd_q      <= {WW{1'b0}};
         timeout_q <= 1'b0;
      end else begin
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_timeout = timeout_q;
`else
   logic unused_max_s;
   assign unused_max_s = (MAX_CYCLES == 32'd0);
   assign wd_hit_s     = 1'b0;
   assign o_timeout    = 1'b0;
`endif

   // Next-state logic: ABORT first, then per-state command/HALT handling.
   always_comb begin
      state_d   = state_q;
      drain_d   = drain_q;
      cnt_clr_s = 1'b0;
      if (abort_s) begin
         state_d = ST_IDLE;
         drain_d = {DW{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (run_cmd_s) begin
                  state_d   = ST_RUN;
                  cnt_clr_s = 1'b1;
               end else if (step_cmd_s) begin
                  state_d = ST_STEP;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_RUN, ST_STEP: begin
               if (i_halt_detected) begin
                  if (DRAIN_CYCLES == 32'd0) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_DRAIN;
                     drain_d = DRAIN_LOAD;
                  end
               end else if (state_q == ST_STEP) begin
                  state_d = ST_IDLE;
               end else if (wd_hit_s) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_DRAIN: begin
               if (drain_q == {DW{1'b0}}) begin
                  state_d = ST_DONE;
               end else begin
                  drain_d = drain_q - DW'(32'd1);
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_IDLE;
               drain_d = {DW{1'b0}};
            end
         endcase
      end
   end

   // Executed-cycle counter: cleared on RUN acceptance, saturates at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr_s) begin
         cnt_d = {SIZE_CNT{1'b0}};
      end else if (step_q && (cnt_q != {SIZE_CNT{1'b1}})) begin
         cnt_d = cnt_q + SIZE_CNT'(32'd1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State, counters and registered outputs decoded from the next state.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= ST_IDLE;
         drain_q   <= {DW{1'b0}};
         cnt_q     <= {SIZE_CNT{1'b0}};
         step_q    <= 1'b0;
         pc_hold_q <= 1'b0;
         done_q    <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         drain_q   <= drain_d;
         cnt_q     <= cnt_d;
         step_q    <= (state_d == ST_RUN) || (state_d == ST_STEP) || (state_d == ST_DRAIN);
         pc_hold_q <= (state_d == ST_DRAIN);
         done_q    <= (state_d == ST_DONE);
         ready_q   <= (state_d == ST_IDLE);
      end
   end

   assign o_step        = step_q;
   assign o_pc_hold     = pc_hold_q;
   assign o_done        = done_q;
   assign o_cmd_ready   = ready_q;
   assign o_state       = state_q;
   assign o_cycle_count = cnt_q;

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// Directed testbench for pipeline_step_ctrl (default build, no watchdog).
// Main instance uses default parameters; a second instance with
// DRAIN_CYCLES=0 and a 4-bit counter covers direct DONE and saturation.
module tb_pipeline_step_ctrl;

   logic        clk;
   logic        reset, valid, halt;
   logic [1:0]  cmd;
   logic        ready, step, hold, done, tmo;
   logic [2:0]  state;
   logic [31:0] count;

   logic        b_reset, b_valid, b_halt;
   logic [1:0]  b_cmd;
   logic        b_ready, b_step, b_hold, b_done, b_tmo;
   logic [2:0]  b_state;
   logic [3:0]  b_count;

   int checks = 0;
   int errors = 0;

   pipeline_step_ctrl u_dut (
      .i_clk(clk), .i_reset(reset), .i_cmd_valid(valid), .i_cmd(cmd),
      .o_cmd_ready(ready), .i_halt_detected(halt), .o_step(step),
      .o_pc_hold(hold), .o_done(done), .o_timeout(tmo), .o_state(state),
      .o_cycle_count(count)
   );

   pipeline_step_ctrl #(.DRAIN_CYCLES(0), .SIZE_CNT(4)) u_dut0 (
      .i_clk(clk), .i_reset(b_reset), .i_cmd_valid(b_valid), .i_cmd(b_cmd),
      .o_cmd_ready(b_ready), .i_halt_detected(b_halt), .o_step(b_step),
      .o_pc_hold(b_hold), .o_done(b_done), .o_timeout(b_tmo), .o_state(b_state),
      .o_cycle_count(b_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic outs(input string tag, input logic [2:0] st, input logic stp,
                       input logic hld, input logic dn, input logic rdy, input logic [31:0] cnt);
      chk({tag, ".state"}, {29'd0, state}, {29'd0, st});
      chk({tag, ".step"},  {31'd0, step},  {31'd0, stp});
      chk({tag, ".hold"},  {31'd0, hold},  {31'd0, hld});
      chk({tag, ".done"},  {31'd0, done},  {31'd0, dn});
      chk({tag, ".ready"}, {31'd0, ready}, {31'd0, rdy});
      chk({tag, ".count"}, count, cnt);
      chk({tag, ".tmo"},   {31'd0, tmo},   32'd0);
   endtask

   task automatic outs_b(input string tag, input logic [2:0] st, input logic stp,
                         input logic hld, input logic dn, input logic [3:0] cnt);
      chk({tag, ".state"}, {29'd0, b_state}, {29'd0, st});
      chk({tag, ".step"},  {31'd0, b_step},  {31'd0, stp});
      chk({tag, ".hold"},  {31'd0, b_hold},  {31'd0, hld});
      chk({tag, ".done"},  {31'd0, b_done},  {31'd0, dn});
      chk({tag, ".count"}, {28'd0, b_count}, {28'd0, cnt});
   endtask

   initial begin
      reset = 1'b1; valid = 1'b0; cmd = 2'b00; halt = 1'b0;
      b_reset = 1'b1; b_valid = 1'b0; b_cmd = 2'b00; b_halt = 1'b0;
      tick; tick;
      outs("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
      reset = 1'b0;

      // Three single steps accumulate the counter.
      for (int i = 0; i < 3; i++) begin
         valid = 1'b1; cmd = 2'b10;
         tick;
         outs("step_on", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'(i));
         valid = 1'b0; cmd = 2'b00;
         tick;
         outs("step_off", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'(i + 1));
      end

      // RUN clears the counter; HALT in the 10th RUN cycle.
      valid = 1'b1; cmd = 2'b01;
      tick;
      outs("run_acc", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      valid = 1'b0; cmd = 2'b00;
      for (int k = 1; k <= 9; k++) begin
         if (k == 5) begin
            valid = 1'b1; cmd = 2'b10;   // STEP while running is ignored
         end
         tick;
         valid = 1'b0; cmd = 2'b00;
         outs("run_cyc", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'(k));
      end
      halt = 1'b1;
      tick;
      outs("drain1", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'd10);
      for (int j = 2; j <= 4; j++) begin
         tick;   // HALT kept high: ignored while draining
         outs("drain_n", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'(9 + j));
      end
      halt = 1'b0;
      tick;
      outs("run_done", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 32'd14);
      valid = 1'b1; cmd = 2'b01;
      tick;
      outs("done_run_ign", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 32'd14);
      cmd = 2'b11;
      tick;
      outs("done_abort", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd14);

      // ABORT with simultaneous HALT in the 5th RUN cycle: ABORT wins.
      cmd = 2'b01;
      tick;
      outs("run2_acc", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      valid = 1'b0; cmd = 2'b00;
      tick; tick; tick; tick;
      outs("run2_c4", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd4);
      valid = 1'b1; cmd = 2'b11; halt = 1'b1;
      tick;
      outs("abort_halt", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5);
      halt = 1'b0; cmd = 2'b01;
      tick;
      outs("run3_clr", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      cmd = 2'b11;
      tick;
      outs("run3_abort", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1);
      cmd = 2'b00;
      tick;
      outs("cmd00", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1);

      // STEP with HALT in its cycle drains for 4 cycles, then DONE.
      cmd = 2'b10;
      tick;
      outs("sh_step", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1);
      valid = 1'b0; cmd = 2'b00; halt = 1'b1;
      tick;
      halt = 1'b0;
      outs("sh_drain1", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'd2);
      for (int j = 2; j <= 4; j++) begin
         tick;
         outs("sh_drain_n", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'(j + 1));
      end
      tick;
      outs("sh_done", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 32'd6);
      valid = 1'b1; cmd = 2'b01;
      tick;
      outs("sh_run_ign", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 32'd6);
      cmd = 2'b11;
      tick;
      outs("sh_abort", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd6);

      // Reset in drain cycle 2, together with a RUN command: reset wins.
      cmd = 2'b10;
      tick;
      valid = 1'b0; cmd = 2'b00; halt = 1'b1;
      tick;
      halt = 1'b0;
      tick;
      outs("rd_drain2", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'd8);
      reset = 1'b1; valid = 1'b1; cmd = 2'b01;
      tick;
      outs("rd_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
      reset = 1'b0; valid = 1'b0; cmd = 2'b00;

      // DRAIN_CYCLES=0 instance: counter saturates, HALT goes straight to DONE.
      b_reset = 1'b0; b_valid = 1'b1; b_cmd = 2'b01;
      tick;
      outs_b("b_run", 3'd1, 1'b1, 1'b0, 1'b0, 4'd0);
      b_valid = 1'b0; b_cmd = 2'b00;
      for (int k = 1; k <= 19; k++) begin
         tick;
      end
      outs_b("b_sat", 3'd1, 1'b1, 1'b0, 1'b0, 4'd15);
      b_halt = 1'b1;
      tick;
      b_halt = 1'b0;
      outs_b("b_done", 3'd4, 1'b0, 1'b0, 1'b1, 4'd15);
      chk("b_tmo", {31'd0, b_tmo}, 32'd0);
      chk("b_ready", {31'd0, b_ready}, 32'd0);
      b_valid = 1'b1; b_cmd = 2'b11;
      tick;
      outs_b("b_abort", 3'd0, 1'b0, 1'b0, 1'b0, 4'd15);
      b_valid = 1'b0; b_cmd = 2'b00;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
